// File: rtl/bullet_pool_if.sv
// Fire-request handshake between player/enemy control logic and the bullet pool.
// Latency: none (wires only); fire_ack is a registered one-cycle pulse from the pool.
// Backpressure: requester holds fire_req until fire_ack; fire_full shows every slot is live.
// Ports: master = requester (drives req/x/y/dir), slave = bullet_pool (drives ack/full).
interface bullet_pool_if #(
  parameter int X_W = 10,
  parameter int Y_W = 10
);
  logic           fire_req;
  logic [X_W-1:0] fire_x;
  logic [Y_W-1:0] fire_y;
  logic           fire_dir;
  logic           fire_ack;
  logic           fire_full;

  modport master (
    output fire_req, fire_x, fire_y, fire_dir,
    input  fire_ack, fire_full
  );

  modport slave (
    input  fire_req, fire_x, fire_y, fire_dir,
    output fire_ack, fire_full
  );
endinterface

// File: rtl/bullet_pool.sv
// Pool of N_BULLETS bullet slots: fire allocation, per-frame movement, round sprite render.
// Latency: fire accepted at the clock edge (ack + live same cycle); pix_on/pix_id 1 cycle after pix_x/pix_y.
// Backpressure: fire_req waits unacked while all slots are live or the shot cooldown is running.
// Ports: clk, rst_n (async active-low), frame_tick, fire (slave handshake), hit_clr (per-slot retire),
//        active (live mask), pix_x/pix_y (scan position) -> pix_on/pix_id (registered render).
module bullet_pool #(
  parameter int N_BULLETS = 4,
  parameter int SIZE      = 6,
  parameter int X_W       = 10,
  parameter int Y_W       = 10,
  parameter int SCREEN_H  = 480,
  parameter int SPEED     = 4,
  parameter int COOLDOWN  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 frame_tick,
  bullet_pool_if.slave         fire,
  input  logic [N_BULLETS-1:0] hit_clr,
  output logic [N_BULLETS-1:0] active,
  input  logic [X_W-1:0]       pix_x,
  input  logic [Y_W-1:0]       pix_y,
  output logic                 pix_on,
  output logic [2:0]           pix_id
);
  // +2 keeps the counter at least one bit wide when COOLDOWN is 0.
  localparam int             CW      = $clog2(COOLDOWN + 2);
  localparam logic [CW-1:0]  COOL_LD = CW'(COOLDOWN);
  localparam logic [Y_W:0]   SPD     = (Y_W+1)'(SPEED);
  localparam logic [Y_W:0]   Y_MAX   = (Y_W+1)'(SCREEN_H - SIZE);
  localparam logic [X_W:0]   SZ_X    = (X_W+1)'(SIZE);
  localparam logic [Y_W:0]   SZ_Y    = (Y_W+1)'(SIZE);

  logic [N_BULLETS-1:0] live_q, live_d;
  logic [N_BULLETS-1:0] dir_q, dir_d;
  logic [X_W-1:0]       x_q [N_BULLETS];
  logic [X_W-1:0]       x_d [N_BULLETS];
  logic [Y_W-1:0]       y_q [N_BULLETS];
  logic [Y_W-1:0]       y_d [N_BULLETS];
  logic [CW-1:0]        cool_q, cool_d;
  logic                 ack_q;
  logic                 pix_on_q, pix_on_d;
  logic [2:0]           pix_id_q, pix_id_d;

  logic                 accept;
  logic [2:0]           slot;

  // Lowest-index dead slot, taken from the registered live mask so a slot
  // retired by hit_clr this cycle is only reusable from the next cycle.
  always_comb begin
    slot = '0;
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (!live_q[i]) slot = 3'(i);
    end
  end

  // ack_q blocks the cycle right after an ack so a slow-dropping req gives one bullet.
  assign accept = fire.fire_req && !ack_q && !(&live_q) && (cool_q == '0);

  // Per-slot next state: hit_clr > fire load > movement.
  always_comb begin
    live_d = live_q;
    dir_d  = dir_q;
    x_d    = x_q;
    y_d    = y_q;
    for (int i = 0; i < N_BULLETS; i++) begin
      if (hit_clr[i] && live_q[i]) begin
        live_d[i] = 1'b0;
      end else if (accept && (slot == 3'(i))) begin
        live_d[i] = 1'b1;
        x_d[i]    = fire.fire_x;
        y_d[i]    = fire.fire_y;
        dir_d[i]  = fire.fire_dir;
      end else if (frame_tick && live_q[i]) begin
        if (!dir_q[i]) begin
          if ({1'b0, y_q[i]} < SPD) live_d[i] = 1'b0;
          else                      y_d[i]    = y_q[i] - SPD[Y_W-1:0];
        end else begin
          if (({1'b0, y_q[i]} + SPD) > Y_MAX) live_d[i] = 1'b0;
          else                                y_d[i]    = y_q[i] + SPD[Y_W-1:0];
        end
      end
    end
  end

  // A fresh shot reloads the counter even if a frame_tick lands in the same cycle.
  always_comb begin
    cool_d = cool_q;
    if (accept)                             cool_d = COOL_LD;
    else if (frame_tick && (cool_q != '0))  cool_d = cool_q - 1'b1;
  end

  // Distance of a sprite cell from the sprite centre, in half-pixels.
  function automatic int fold(input logic [4:0] d);
    int t;
    t = 2 * int'(d) - (SIZE - 1);
    return (t < 0) ? -t : t;
  endfunction

  // Offsets use one extra bit so a scan left of / above a bullet wraps to a
  // large value instead of aliasing into the sprite box.
  logic [X_W:0]         dx [N_BULLETS];
  logic [Y_W:0]         dy [N_BULLETS];
  logic [N_BULLETS-1:0] lit;

  always_comb begin
    lit      = '0;
    pix_id_d = '0;
    for (int i = 0; i < N_BULLETS; i++) begin
      dx[i]  = {1'b0, pix_x} - {1'b0, x_q[i]};
      dy[i]  = {1'b0, pix_y} - {1'b0, y_q[i]};
      lit[i] = live_q[i] && (dx[i] < SZ_X) && (dy[i] < SZ_Y) &&
               ((fold(dx[i][4:0]) + fold(dy[i][4:0])) <= SIZE);
    end
    for (int i = N_BULLETS - 1; i >= 0; i--) begin
      if (lit[i]) pix_id_d = 3'(i);
    end
    pix_on_d = |lit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q   <= '0;
      dir_q    <= '0;
      cool_q   <= '0;
      ack_q    <= 1'b0;
      pix_on_q <= 1'b0;
      pix_id_q <= '0;
      for (int i = 0; i < N_BULLETS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
      end
    end else begin
      live_q   <= live_d;
      dir_q    <= dir_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cool_q   <= cool_d;
      ack_q    <= accept;
      pix_on_q <= pix_on_d;
      pix_id_q <= pix_id_d;
    end
  end

  assign fire.fire_ack  = ack_q;
  assign fire.fire_full = &live_q;
  assign active         = live_q;
  assign pix_on         = pix_on_q;
  assign pix_id         = pix_id_q;
endmodule

// File: tb/tb_bullet_pool.sv
// Self-checking bench for bullet_pool: directed scenarios plus randomized traffic
// against a reference model of the slot pool, cooldown and sprite shape.
// Drives inputs #1 after the rising edge and samples outputs there too.
module tb_bullet_pool;
  localparam int N = 4, SZ = 6, XW = 10, YW = 10, SH = 480, SPD = 4, CD = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_tick = 1'b0;
  logic [N-1:0]  hit_clr = '0;
  logic [N-1:0]  active;
  logic [XW-1:0] pix_x = '0;
  logic [YW-1:0] pix_y = '0;
  logic          pix_on;
  logic [2:0]    pix_id;

  bullet_pool_if #(.X_W(XW), .Y_W(YW)) fif ();

  bullet_pool #(
    .N_BULLETS(N), .SIZE(SZ), .X_W(XW), .Y_W(YW),
    .SCREEN_H(SH), .SPEED(SPD), .COOLDOWN(CD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .fire(fif),
    .hit_clr(hit_clr), .active(active), .pix_x(pix_x), .pix_y(pix_y),
    .pix_on(pix_on), .pix_id(pix_id)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int fails = 0;

  // Reference model: plain integers per slot.
  int mlive [N];
  int mx [N];
  int my [N];
  int mdir [N];
  int mcool;
  bit mack;
  bit mpon;
  int mpid;

  task automatic m_clear();
    for (int i = 0; i < N; i++) begin mlive[i] = 0; mx[i] = 0; my[i] = 0; mdir[i] = 0; end
    mcool = 0; mack = 0; mpon = 0; mpid = 0;
  endtask

  function automatic logic [N-1:0] m_mask();
    logic [N-1:0] m;
    for (int i = 0; i < N; i++) m[i] = (mlive[i] != 0);
    return m;
  endfunction

  function automatic bit covers(int i, int px, int py);
    int dx, dy, ex, ey;
    dx = px - mx[i];
    dy = py - my[i];
    if (dx < 0 || dy < 0 || dx >= SZ || dy >= SZ) return 1'b0;
    ex = 2 * dx - (SZ - 1); if (ex < 0) ex = -ex;
    ey = 2 * dy - (SZ - 1); if (ey < 0) ey = -ey;
    return (ex + ey) <= SZ;
  endfunction

  // One clock: predict from current inputs, advance the DUT, commit prediction.
  task automatic step();
    int nl [N]; int nx [N]; int ny [N]; int nd [N];
    int ncool, slot, npid;
    bit acc, npon;
    npon = 0; npid = 0;
    for (int i = N - 1; i >= 0; i--)
      if (mlive[i] != 0 && covers(i, int'(pix_x), int'(pix_y))) begin npon = 1; npid = i; end
    slot = -1;
    for (int i = N - 1; i >= 0; i--) if (mlive[i] == 0) slot = i;
    acc = fif.fire_req && !mack && slot >= 0 && mcool == 0;
    for (int i = 0; i < N; i++) begin
      nl[i] = mlive[i]; nx[i] = mx[i]; ny[i] = my[i]; nd[i] = mdir[i];
      if (hit_clr[i] && mlive[i] != 0) nl[i] = 0;
      else if (acc && i == slot) begin
        nl[i] = 1; nx[i] = int'(fif.fire_x); ny[i] = int'(fif.fire_y); nd[i] = int'(fif.fire_dir);
      end else if (frame_tick && mlive[i] != 0) begin
        if (mdir[i] == 0) begin
          if (my[i] < SPD) nl[i] = 0; else ny[i] = my[i] - SPD;
        end else begin
          if (my[i] + SPD > SH - SZ) nl[i] = 0; else ny[i] = my[i] + SPD;
        end
      end
    end
    ncool = mcool;
    if (acc) ncool = CD;
    else if (frame_tick && mcool > 0) ncool = mcool - 1;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin mlive[i] = nl[i]; mx[i] = nx[i]; my[i] = ny[i]; mdir[i] = nd[i]; end
    mcool = ncool; mack = acc; mpon = npon; mpid = npid;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fif.fire_req = 1'b0; fif.fire_x = '0; fif.fire_y = '0; fif.fire_dir = 1'b0;
    frame_tick = 1'b0; hit_clr = '0; pix_x = '0; pix_y = '0;
    m_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin frame_tick = 1'b1; step(); frame_tick = 1'b0; end
  endtask

  task automatic probe(input int x, input int y);
    pix_x = XW'(x); pix_y = YW'(y); step();
  endtask

  // Holds fire_req until ack (bounded); waited = cycles taken, -1 on timeout.
  task automatic fire_one(input int x, input int y, input bit d, output int waited);
    fif.fire_req = 1'b1; fif.fire_x = XW'(x); fif.fire_y = YW'(y); fif.fire_dir = d;
    waited = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (fif.fire_ack) begin waited = k; break; end
    end
    fif.fire_req = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk++; if (active !== 4'b0000) begin fails++; $display("FAIL reset_active got=%b exp=0000", active); end
    chk++; if (fif.fire_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got=%b exp=0", fif.fire_ack); end
    chk++; if (fif.fire_full !== 1'b0) begin fails++; $display("FAIL reset_full got=%b exp=0", fif.fire_full); end
    chk++; if (pix_on !== 1'b0) begin fails++; $display("FAIL reset_pix_on got=%b exp=0", pix_on); end
    chk++; if (pix_id !== 3'd0) begin fails++; $display("FAIL reset_pix_id got=%0d exp=0", pix_id); end
  endtask

  task automatic test_fire();
    int acks = 0;
    do_reset();
    fif.fire_req = 1'b1; fif.fire_x = 10'd100; fif.fire_y = 10'd400; fif.fire_dir = 1'b0;
    for (int k = 0; k < 4; k++) begin step(); acks += int'(fif.fire_ack); end
    fif.fire_req = 1'b0;
    chk++; if (acks != 1) begin fails++; $display("FAIL fire_ack_count got=%0d exp=1", acks); end
    chk++; if (active !== 4'b0001) begin fails++; $display("FAIL fire_active got=%b exp=0001", active); end
    probe(102, 400);
    chk++; if (pix_on !== 1'b1 || pix_id !== 3'd0) begin fails++; $display("FAIL fire_pos got=%b/%0d exp=1/0", pix_on, pix_id); end
    probe(102, 399);
    chk++; if (pix_on !== 1'b0) begin fails++; $display("FAIL fire_above got=%b exp=0", pix_on); end
  endtask

  task automatic test_move();
    int w;
    do_reset();
    fire_one(50, 10, 1'b0, w);
    for (int k = 1; k <= 2; k++) begin
      tick_n(1);
      probe(52, 10 - 4 * k);
      chk++; if (pix_on !== 1'b1) begin fails++; $display("FAIL move_up_%0d got=%b exp=1", k, pix_on); end
    end
    tick_n(1);
    chk++; if (active !== 4'b0000) begin fails++; $display("FAIL move_up_retire got=%b exp=0000", active); end
    do_reset();
    fire_one(300, 466, 1'b1, w);
    for (int k = 1; k <= 2; k++) begin
      tick_n(1);
      probe(302, 466 + 4 * k);
      chk++; if (pix_on !== 1'b1) begin fails++; $display("FAIL move_dn_%0d got=%b exp=1", k, pix_on); end
    end
    tick_n(1);
    chk++; if (active !== 4'b0000) begin fails++; $display("FAIL move_dn_retire got=%b exp=0000", active); end
  endtask

  task automatic test_full();
    int w, acks;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      fire_one(100 + 100 * k, 200, 1'b1, w);
      chk++; if (w < 0) begin fails++; $display("FAIL full_fire_%0d got=timeout exp=ack", k); end
      tick_n(CD);
    end
    chk++; if (active !== 4'b1111 || fif.fire_full !== 1'b1) begin fails++; $display("FAIL full_mask got=%b/%b exp=1111/1", active, fif.fire_full); end
    fif.fire_req = 1'b1; fif.fire_x = 10'd600; fif.fire_y = 10'd100; fif.fire_dir = 1'b0;
    acks = 0;
    for (int k = 0; k < 5; k++) begin step(); acks += int'(fif.fire_ack); end
    chk++; if (acks != 0) begin fails++; $display("FAIL full_no_ack got=%0d exp=0", acks); end
    hit_clr = 4'b0100; step(); hit_clr = '0;
    chk++; if (active !== 4'b1011 || fif.fire_ack !== 1'b0) begin fails++; $display("FAIL full_hit got=%b/%b exp=1011/0", active, fif.fire_ack); end
    step();
    chk++; if (active !== 4'b1111 || fif.fire_ack !== 1'b1) begin fails++; $display("FAIL full_realloc got=%b/%b exp=1111/1", active, fif.fire_ack); end
    fif.fire_req = 1'b0;
    probe(602, 100);
    chk++; if (pix_on !== 1'b1 || pix_id !== 3'd2) begin fails++; $display("FAIL full_slot2 got=%b/%0d exp=1/2", pix_on, pix_id); end
  endtask

  task automatic test_simul();
    int w, acks;
    do_reset();
    fire_one(100, 200, 1'b1, w);
    tick_n(CD);
    fif.fire_req = 1'b1; fif.fire_x = 10'd300; fif.fire_y = 10'd300; fif.fire_dir = 1'b0;
    frame_tick = 1'b1; step(); frame_tick = 1'b0; fif.fire_req = 1'b0;
    chk++; if (fif.fire_ack !== 1'b1 || active !== 4'b0011) begin fails++; $display("FAIL sim_accept got=%b/%b exp=1/0011", fif.fire_ack, active); end
    probe(302, 300);
    chk++; if (pix_on !== 1'b1 || pix_id !== 3'd1) begin fails++; $display("FAIL sim_new_holds got=%b/%0d exp=1/1", pix_on, pix_id); end
    probe(102, 236);
    chk++; if (pix_on !== 1'b1 || pix_id !== 3'd0) begin fails++; $display("FAIL sim_old_moved got=%b/%0d exp=1/0", pix_on, pix_id); end
    fif.fire_req = 1'b1; fif.fire_x = 10'd500; fif.fire_y = 10'd100; fif.fire_dir = 1'b0;
    acks = 0;
    for (int k = 0; k < CD; k++) begin tick_n(1); acks += int'(fif.fire_ack); end
    chk++; if (acks != 0) begin fails++; $display("FAIL sim_cooldown_hold got=%0d exp=0", acks); end
    step();
    chk++; if (fif.fire_ack !== 1'b1) begin fails++; $display("FAIL sim_cooldown_8 got=%b exp=1", fif.fire_ack); end
    fif.fire_req = 1'b0;
    hit_clr = 4'b0001; frame_tick = 1'b1; step(); hit_clr = '0; frame_tick = 1'b0;
    chk++; if (active !== 4'b0110) begin fails++; $display("FAIL sim_hit_tick got=%b exp=0110", active); end
    probe(302, 264);
    chk++; if (pix_on !== 1'b1 || pix_id !== 3'd1) begin fails++; $display("FAIL sim_s1_pos got=%b/%0d exp=1/1", pix_on, pix_id); end
    probe(502, 96);
    chk++; if (pix_on !== 1'b1 || pix_id !== 3'd2) begin fails++; $display("FAIL sim_s2_pos got=%b/%0d exp=1/2", pix_on, pix_id); end
  endtask

  task automatic test_render();
    int w;
    int px [8] = '{200, 202, 203, 206, 199, 205, 202, 200};
    int py [8] = '{300, 300, 302, 300, 300, 302, 305, 305};
    bit eo [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
    do_reset();
    fire_one(200, 300, 1'b0, w);
    for (int k = 0; k < 8; k++) begin
      probe(px[k], py[k]);
      chk++; if (pix_on !== eo[k] || pix_id !== 3'd0) begin fails++; $display("FAIL render_%0d_%0d got=%b/%0d exp=%b/0", px[k], py[k], pix_on, pix_id, eo[k]); end
    end
    tick_n(CD);
    fire_one(400, 300, 1'b0, w);
    tick_n(CD);
    fire_one(10, 50, 1'b1, w);
    tick_n(CD);
    fire_one(400, 236, 1'b0, w);
    probe(402, 236);
    chk++; if (pix_on !== 1'b1 || pix_id !== 3'd1) begin fails++; $display("FAIL render_overlap got=%b/%0d exp=1/1", pix_on, pix_id); end
    hit_clr = 4'b0010; step(); hit_clr = '0;
    probe(402, 236);
    chk++; if (pix_on !== 1'b1 || pix_id !== 3'd3) begin fails++; $display("FAIL render_overlap_s3 got=%b/%0d exp=1/3", pix_on, pix_id); end
  endtask

  task automatic test_async_reset();
    int w;
    do_reset();
    fire_one(100, 200, 1'b1, w); tick_n(CD);
    fire_one(200, 200, 1'b1, w); tick_n(CD);
    fire_one(300, 200, 1'b1, w);
    probe(302, 200);
    chk++; if (pix_on !== 1'b1 || active !== 4'b0111) begin fails++; $display("FAIL arst_pre got=%b/%b exp=1/0111", pix_on, active); end
    fif.fire_req = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk++; if (active !== 4'b0000) begin fails++; $display("FAIL arst_active got=%b exp=0000", active); end
    chk++; if (pix_on !== 1'b0) begin fails++; $display("FAIL arst_pix_on got=%b exp=0", pix_on); end
    @(posedge clk); #1;
    chk++; if (fif.fire_ack !== 1'b0) begin fails++; $display("FAIL arst_no_ack got=%b exp=0", fif.fire_ack); end
    fif.fire_req = 1'b0;
    m_clear();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int j, tx, ty;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (fif.fire_req && fif.fire_ack) fif.fire_req = 1'b0;
      else if (!fif.fire_req && $urandom_range(0, 5) == 0) begin
        fif.fire_req = 1'b1;
        fif.fire_x = XW'($urandom_range(0, 600));
        fif.fire_y = YW'($urandom_range(0, SH - SZ));
        fif.fire_dir = 1'($urandom_range(0, 1));
      end
      frame_tick = ($urandom_range(0, 3) == 0);
      hit_clr = ($urandom_range(0, 19) == 0) ? N'($urandom) : '0;
      j = $urandom_range(0, N - 1);
      tx = mx[j] + $urandom_range(0, SZ + 1) - 1; if (tx < 0) tx = 0;
      ty = my[j] + $urandom_range(0, SZ + 1) - 1; if (ty < 0) ty = 0;
      pix_x = XW'(tx); pix_y = YW'(ty);
      step();
      chk++; if (active !== m_mask()) begin fails++; $display("FAIL rnd_active c=%0d got=%b exp=%b", c, active, m_mask()); end
      chk++; if (fif.fire_ack !== mack) begin fails++; $display("FAIL rnd_ack c=%0d got=%b exp=%b", c, fif.fire_ack, mack); end
      chk++; if (fif.fire_full !== (&m_mask())) begin fails++; $display("FAIL rnd_full c=%0d got=%b exp=%b", c, fif.fire_full, &m_mask()); end
      chk++; if (pix_on !== mpon) begin fails++; $display("FAIL rnd_pix_on c=%0d got=%b exp=%b", c, pix_on, mpon); end
      chk++; if (pix_id !== 3'(mpid)) begin fails++; $display("FAIL rnd_pix_id c=%0d got=%0d exp=%0d", c, pix_id, mpid); end
      if (fails > 40) break;
    end
    fif.fire_req = 1'b0; frame_tick = 1'b0; hit_clr = '0;
  endtask

  initial begin
    fif.fire_req = 1'b0; fif.fire_x = '0; fif.fire_y = '0; fif.fire_dir = 1'b0;
    m_clear();
    test_reset();
    test_fire();
    test_move();
    test_full();
    test_simul();
    test_render();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", chk, fails);
    $finish;
  end
endmodule
